vec_pipe_reg: RTL and testbench

- Parametrised, multi-lane pipeline register for the vector datapath; next generation of the plain reset/clear flop.
- Two-entry skid buffer with valid/ready handshake on both sides, synchronous flush and per-lane mask.
- Sits between vector pipeline stages (decode→execute, execute→writeback).
- Sustains one transfer per cycle under backpressure without a combinational ready path.

---
 rtl/vec_pipe_reg.sv | 147 ++++++++++++++
 tb/tb_vec_pipe_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_pipe_reg.sv
// vec_pipe_reg: multi-lane vector pipeline register built as a two-entry
// skid buffer. It sits between vector pipeline stages and sustains one
// transfer per cycle under backpressure. in_ready comes straight from a
// flop and has no combinational path from out_ready.
//
// Optional build macro:
//   VEC_PIPE_MASK_ZERO_EN - lanes whose mask bit is 0 are stored as RESET_VAL
//                           when captured. When the macro is undefined, lanes
//                           are stored verbatim and the mask is only carried.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      synchronous clear, active-high; takes priority over transfers
//   in_valid   upstream beat valid
//   in_ready   buffer can accept (registered)
//   in_data    LANES*WIDTH input, lane i at [i*WIDTH +: WIDTH]
//   in_mask    per-lane enable, bit i = lane i
//   out_valid  main entry holds a valid beat
//   out_ready  downstream accepts
//   out_data   registered output data (main entry)
//   out_mask   mask travelling with out_data
//   level      occupancy: 0, 1 or 2
module vec_pipe_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      LANES     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_mask,
    output logic [1:0]             level
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MAIN  = 2'd1,
        S_BOTH  = 2'd2
    } state_t;

    localparam logic [LANES*WIDTH-1:0] DATA_RST = {LANES{RESET_VAL}};

    state_t                   state, state_next;
    logic                     in_ready_q;
    logic [LANES*WIDTH-1:0]   main_data, skid_data;
    logic [LANES-1:0]         main_mask, skid_mask;
    logic [LANES*WIDTH-1:0]   captured;
    logic                     accept, emit;
    logic                     load_main_in, load_skid_in, move_skid;

    assign accept    = in_valid && in_ready_q;
    assign emit      = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != S_EMPTY);
    assign out_data  = main_data;
    assign out_mask  = main_mask;
    assign level     = state;

    // Lane treatment at capture time.
    always_comb begin
        captured = in_data;
`ifdef VEC_PIPE_MASK_ZERO_EN
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!in_mask[i]) begin
                captured[i*WIDTH +: WIDTH] = RESET_VAL;
            end
        end
`endif
    end

    always_comb begin
        state_next   = state;
        load_main_in = 1'b0;
        load_skid_in = 1'b0;
        move_skid    = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_next   = S_MAIN;
                    load_main_in = 1'b1;
                end
            end
            S_MAIN: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_next   = S_BOTH;
                    load_skid_in = 1'b1;
                end else if (emit) begin
                    state_next   = S_EMPTY;
                end
            end
            S_BOTH: begin
                if (emit) begin
                    state_next = S_MAIN;
                    move_skid  = 1'b1;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_data  <= DATA_RST;
            main_mask  <= '0;
            skid_data  <= DATA_RST;
            skid_mask  <= '0;
        end else if (flush) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_data  <= DATA_RST;
            main_mask  <= '0;
            skid_data  <= DATA_RST;
            skid_mask  <= '0;
        end else begin
            state      <= state_next;
            // Registered look-ahead: ready next cycle iff the skid will be free.
            in_ready_q <= (state_next != S_BOTH);
            if (load_main_in) begin
                main_data <= captured;
                main_mask <= in_mask;
            end else if (move_skid) begin
                main_data <= skid_data;
                main_mask <= skid_mask;
            end
            if (load_skid_in) begin
                skid_data <= captured;
                skid_mask <= in_mask;
            end else if (move_skid) begin
                skid_data <= DATA_RST;
                skid_mask <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vec_pipe_reg.sv
module tb_vec_pipe_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = WIDTH * LANES;
    localparam logic [WIDTH-1:0] RV = 32'h0;

    typedef struct packed {
        logic [DW-1:0]    d;
        logic [LANES-1:0] m;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic [LANES-1:0] in_mask = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic [LANES-1:0] out_mask;
    logic [1:0]       level;

    int tests = 0;
    int fails = 0;
    beat_t q[$];

    vec_pipe_reg #(.WIDTH(WIDTH), .LANES(LANES), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mask(out_mask),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a beat is a (data, mask) pair; masked-off lanes read as RV
    // in the zeroing build, otherwise data passes untouched.
    function automatic beat_t model(input logic [DW-1:0] d, input logic [LANES-1:0] m);
        beat_t b;
        b.d = d;
        b.m = m;
`ifdef VEC_PIPE_MASK_ZERO_EN
        for (int i = 0; i < LANES; i++)
            if (!m[i]) b.d[i*WIDTH +: WIDTH] = RV;
`endif
        return b;
    endfunction

    function automatic logic [DW-1:0] lanes4(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    // Stimulus side: every accepted beat pushes its expected response.
    always @(negedge clk)
        if (reset && !flush && in_valid && in_ready)
            q.push_back(model(in_data, in_mask));

    // Monitor: compares each emitted beat against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            if (flush) begin
                q.delete();
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", out_data, '0);
                    check("unexpected_beat_valid", 1, 0);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_mask", {{(DW-LANES){1'b0}}, out_mask}, {{(DW-LANES){1'b0}}, e.m});
                end
            end
        end
    end

    always @(negedge reset) q.delete();

    // Occupancy/handshake follow from the number of outstanding beats.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            check("level", {{(DW-2){1'b0}}, level}, q.size());
            check("in_ready", {{(DW-1){1'b0}}, in_ready}, (q.size() < 2) ? 1 : 0);
            check("out_valid", {{(DW-1){1'b0}}, out_valid}, (q.size() != 0) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, hold until accepted (bounded), then drop in_valid.
    task automatic offer(input logic [DW-1:0] d, input logic [LANES-1:0] m);
        bit ok;
        ok = 0;
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("offer_timeout", 0, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d tests %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        // Reset / idle
        cyc();
        cyc();
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, {LANES{RV}});
        check("rst_out_mask", out_mask, 0);
        cyc();

        // Single beat
        out_ready = 1'b1;
        offer(lanes4(4, 3, 2, 1), 4'b1111);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, lanes4(4, 3, 2, 1));
        cyc();
        check("single_gone", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        offer({LANES{32'h11}}, 4'hF);
        offer({LANES{32'h22}}, 4'hF);
        in_data  = {LANES{32'h33}};
        in_mask  = 4'hF;
        in_valid = 1'b1;
        cyc();
        cyc();
        check("bp_level", level, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_head", out_data, {LANES{32'h11}});
        out_ready = 1'b1;
        offer({LANES{32'h33}}, 4'hF);
        repeat (4) cyc();

        // Flush with a simultaneous offer
        out_ready = 1'b0;
        offer({LANES{32'hAA}}, 4'hF);
        offer({LANES{32'hBB}}, 4'hF);
        check("fl_pre_level", level, 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = {LANES{32'h44}};
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_level", level, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_out_data", out_data, {LANES{RV}});
        out_ready = 1'b1;
        repeat (4) cyc();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        offer({LANES{32'h55}}, 4'hF);
        check("ar_pre_level", level, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_level", level, 0);
        check("ar_out_data", out_data, {LANES{RV}});
        check("ar_out_mask", out_mask, 0);
        check("ar_in_ready", in_ready, 1);
        cyc();
        reset = 1'b1;
        cyc();

        // Mask
        out_ready = 1'b1;
        offer(lanes4(32'hA, 32'hB, 32'hC, 32'hD), 4'b0101);
`ifdef VEC_PIPE_MASK_ZERO_EN
        check("mask_data", out_data, lanes4(0, 32'hB, 0, 32'hD));
`else
        check("mask_data", out_data, lanes4(32'hA, 32'hB, 32'hC, 32'hD));
`endif
        check("mask_mask", out_mask, 4'b0101);
        repeat (2) cyc();

        // Randomised traffic
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_mask   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cyc();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
